// File: rtl/bus_initiator.sv
// bus_initiator: four-phase handshake register-bus initiator with per-wait-state timeout
module bus_initiator #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [31:0]           rsp_status,
  output logic                  rsp_fault,
  output logic                  rsp_timeout,
  output logic                  register_address_valid,
  output logic [ADDR_WIDTH-1:0] reg_address,
  output logic                  RW,
  output logic                  handshake_1,
  input  logic                  handshake_2,
  output logic [31:0]           data_out,
  input  logic [31:0]           data_in,
  input  logic                  nFault
);
  typedef enum logic [2:0] {IDLE, SETUP, DATA_REQ, DATA_REL, STAT_REQ, STAT_REL, DONE} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [31:0] rdata_q, status_q;
  logic fault_q, req, ev, to;
  assign req = state == DATA_REQ || state == STAT_REQ;
  assign ev = handshake_2 == req;
  assign to = cnt == 16'(TIMEOUT_CYCLES - 1);
  // transaction sequencer: accept, walk the four handshake phases, report in DONE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cmd_ready <= 1'b0;
      handshake_1 <= 1'b0;
      register_address_valid <= 1'b0;
      reg_address <= '0;
      RW <= 1'b0;
      data_out <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_status <= '0;
      rsp_fault <= 1'b0;
      rsp_timeout <= 1'b0;
      rdata_q <= '0;
      status_q <= '0;
      fault_q <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        cmd_ready <= !(cmd_ready && cmd_valid);
        if (cmd_ready && cmd_valid) begin
          state <= SETUP;
          cnt <= '0;
          RW <= cmd_rw;
          reg_address <= cmd_addr;
          data_out <= cmd_rw ? '0 : cmd_wdata;
          register_address_valid <= 1'b1;
          rdata_q <= '0;
          status_q <= '0;
          fault_q <= 1'b0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
        cmd_ready <= 1'b1;
      end else if (ev || to) begin
        cnt <= '0;
        if (ev && state == DATA_REQ && RW) rdata_q <= data_in;
        if (ev && state == STAT_REQ) status_q <= data_in;
        if (ev && req && nFault == 1'b0) fault_q <= 1'b1;
        if (!ev || state == STAT_REL) begin
          state <= DONE;
          handshake_1 <= 1'b0;
          register_address_valid <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_timeout <= !ev;
          rsp_rdata <= ev ? rdata_q : '0;
          rsp_status <= ev ? status_q : '0;
          rsp_fault <= fault_q;
        end else begin
          state <= state_t'(state + 3'd1);
          handshake_1 <= !req;
        end
      end else cnt <= cnt + 16'd1;
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: randomized transaction bench with a cycle-timeline reference model
module tb_bus_initiator;
  localparam int T = 8;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_rw = 0, handshake_2 = 0, nFault = 1;
  logic [7:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0, data_in = 0;
  logic cmd_ready, rsp_valid, rsp_fault, rsp_timeout, register_address_valid, RW, handshake_1;
  logic [31:0] rsp_rdata, rsp_status, data_out;
  logic [7:0] reg_address;
  int nvec = 0, nerr = 0, cyc = 0, acc = 0, last_done = -1;
  bit chk = 0, x_ready, x_hs1, x_rav, x_valid, x_in, x_rw, x_fault, x_tmo;
  logic [7:0] x_addr;
  logic [31:0] x_dout, x_rdata, x_status;
  bit e_hs1[64], e_rav[64], e_done[64], s_hs2[64], s_nf[64];
  logic [31:0] s_din[64];

  bus_initiator #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_fault(rsp_fault), .rsp_timeout(rsp_timeout),
    .register_address_valid(register_address_valid), .reg_address(reg_address), .RW(RW),
    .handshake_1(handshake_1), .handshake_2(handshake_2), .data_out(data_out),
    .data_in(data_in), .nFault(nFault)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    cmp(name, 32'(act), 32'(exp));
  endtask

  always @(negedge clk)
    if (chk) begin
      cmp1("cmd_ready", cmd_ready, x_ready);
      cmp1("handshake_1", handshake_1, x_hs1);
      cmp1("reg_addr_valid", register_address_valid, x_rav);
      cmp1("rsp_valid", rsp_valid, x_valid);
      cmp("rsp_rdata", rsp_rdata, x_rdata);
      cmp("rsp_status", rsp_status, x_status);
      cmp1("rsp_fault", rsp_fault, x_fault);
      cmp1("rsp_timeout", rsp_timeout, x_tmo);
      if (x_in) begin
        cmp("reg_address", 32'(reg_address), 32'(x_addr));
        cmp1("RW", RW, x_rw);
        cmp("data_out", data_out, x_dout);
      end
      if (rsp_valid) last_done = cyc;
    end

  task automatic cyc_end();
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic check_reset_vals();
    cmp1("rst_cmd_ready", cmd_ready, 1'b0);
    cmp1("rst_handshake_1", handshake_1, 1'b0);
    cmp1("rst_reg_addr_valid", register_address_valid, 1'b0);
    cmp1("rst_rsp_valid", rsp_valid, 1'b0);
    cmp1("rst_rsp_fault", rsp_fault, 1'b0);
    cmp1("rst_rsp_timeout", rsp_timeout, 1'b0);
    cmp1("rst_RW", RW, 1'b0);
    cmp("rst_reg_address", 32'(reg_address), 32'd0);
    cmp("rst_data_out", data_out, 32'd0);
    cmp("rst_rsp_rdata", rsp_rdata, 32'd0);
    cmp("rst_rsp_status", rsp_status, 32'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1;
    chk = 0;
    #1 check_reset_vals();
    @(posedge clk);
    #1 check_reset_vals();
    reset = 0;
    cmd_valid = 0;
    handshake_2 = 0;
    x_rdata = 0; x_status = 0; x_fault = 0; x_tmo = 0;
    x_ready = 0; x_hs1 = 0; x_rav = 0; x_valid = 0; x_in = 0;
    chk = 1;
    cyc_end();
  endtask

  task automatic idle(input int m);
    for (int i = 0; i < m; i++) begin
      cmd_valid = 0; cmd_rw = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
      handshake_2 = 1'($urandom); data_in = $urandom; nFault = 1'($urandom);
      x_ready = 1; x_hs1 = 0; x_rav = 0; x_valid = 0; x_in = 0;
      cyc_end();
    end
  endtask

  // d0: cycles stale acknowledge stays high in SETUP; d1..d4: responder delay per phase.
  // A delay >= T means the awaited edge never comes in time.
  task automatic run_txn(input bit rw, input logic [7:0] addr, input logic [31:0] wd, rd, st,
                         input bit nf1, nf2, input int d0, d1, d2, d3, d4, input int abort_k);
    int d[5];
    int n, len;
    bit req, tmo, flt, nf;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4;
    n = 0; tmo = 0; flt = 0;
    for (int p = 0; p < 5; p++)
      if (!tmo) begin
        req = p == 1 || p == 3;
        nf = p == 1 ? nf1 : nf2;
        len = d[p] >= T ? T : d[p] + 1;
        for (int j = 0; j < len; j++) begin
          n++;
          e_hs1[n] = req; e_rav[n] = 1; e_done[n] = 0;
          s_hs2[n] = req ? j == d[p] : j < d[p];
          s_din[n] = req && j == d[p] ? (p == 1 ? rd : st) : $urandom;
          s_nf[n] = req && j == d[p] ? nf : 1'($urandom);
        end
        if (d[p] >= T) tmo = 1;
        else if (req && !nf) flt = 1;
      end
    n++;
    e_hs1[n] = 0; e_rav[n] = 0; e_done[n] = 1;
    s_hs2[n] = s_hs2[n-1]; s_din[n] = $urandom; s_nf[n] = 1'($urandom);
    last_done = -1;
    cmd_valid = 1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd;
    handshake_2 = d0 > 0; data_in = $urandom; nFault = 1'($urandom);
    x_ready = 1; x_hs1 = 0; x_rav = 0; x_valid = 0; x_in = 0;
    acc = cyc;
    cyc_end();
    for (int k = 1; k <= n; k++) begin
      cmd_valid = 1'($urandom); cmd_rw = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;
      handshake_2 = s_hs2[k]; data_in = s_din[k]; nFault = s_nf[k];
      if (k == abort_k) begin
        do_reset();
        return;
      end
      x_ready = 0; x_hs1 = e_hs1[k]; x_rav = e_rav[k]; x_valid = e_done[k]; x_in = e_rav[k];
      x_addr = addr; x_rw = rw; x_dout = rw ? 32'd0 : wd;
      if (e_done[k]) begin
        x_rdata = tmo ? 32'd0 : (rw ? rd : 32'd0);
        x_status = tmo ? 32'd0 : st;
        x_fault = flt;
        x_tmo = tmo;
      end
      cyc_end();
    end
    cmd_valid = 0;
  endtask

  function automatic int rdly();
    int r;
    r = $urandom_range(9, 0);
    return r < 7 ? int'($urandom_range(2, 0)) : (r == 7 ? T - 1 : (r == 8 ? T : T + 3));
  endfunction

  task automatic lit_read_0x03();
    run_txn(1, 8'h03, 32'h0, 32'h12345678, 32'h1, 1, 1, 0, 0, 0, 0, 0, -1);
    cmp("lit_min_latency", 32'(last_done - acc), 32'd6);
    cmp("lit_read_rdata", rsp_rdata, 32'h12345678);
    cmp("lit_read_status", rsp_status, 32'h00000001);
    cmp1("lit_read_fault", rsp_fault, 1'b0);
    cmp1("lit_read_timeout", rsp_timeout, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1 do_reset();
    idle(2);
    lit_read_0x03();
    run_txn(0, 8'h05, 32'hDEADBEEF, 32'h0, 32'h00000002, 1, 1, 1, 2, 0, 1, 3, -1);
    cmp("lit_write_rdata", rsp_rdata, 32'd0);
    cmp("lit_write_status", rsp_status, 32'h00000002);
    idle(1);
    run_txn(1, 8'h7F, 32'h0, 32'h55555555, 32'hAAAAAAAA, 0, 1, 0, 1, 0, 0, 0, -1);
    cmp1("lit_fault_flag", rsp_fault, 1'b1);
    cmp("lit_fault_rdata", rsp_rdata, 32'h55555555);
    cmp("lit_fault_status", rsp_status, 32'hAAAAAAAA);
    run_txn(1, 8'h10, 32'h0, 32'h11111111, 32'h22222222, 1, 1, 0, 1000, 0, 0, 0, -1);
    cmp("lit_data_timeout_at", 32'(last_done - (acc + 2)), 32'd8);
    cmp1("lit_data_timeout", rsp_timeout, 1'b1);
    cmp("lit_data_timeout_rdata", rsp_rdata, 32'd0);
    idle(1);
    run_txn(1, 8'h21, 32'h0, 32'h33333333, 32'h44444444, 1, 1, 1000, 0, 0, 0, 0, -1);
    cmp("lit_stale_timeout_at", 32'(last_done - acc), 32'd9);
    cmp1("lit_stale_timeout", rsp_timeout, 1'b1);
    run_txn(1, 8'h22, 32'h0, 32'h66666666, 32'h77777777, 1, 1, 0, T - 1, 0, T - 1, 0, -1);
    cmp("lit_edge_latency", 32'(last_done - acc), 32'd20);
    cmp1("lit_edge_no_timeout", rsp_timeout, 1'b0);
    cmp("lit_edge_rdata", rsp_rdata, 32'h66666666);
    run_txn(1, 8'h23, 32'h0, 32'h88888888, 32'h99999999, 0, 1, 0, 0, 0, T, 0, -1);
    cmp1("lit_stat_timeout", rsp_timeout, 1'b1);
    cmp1("lit_stat_timeout_fault", rsp_fault, 1'b1);
    cmp("lit_stat_timeout_status", rsp_status, 32'd0);
    idle(1);
    run_txn(1, 8'h31, 32'h0, 32'hCAFEF00D, 32'h5, 1, 1, 0, 0, 0, 0, 0, 4);
    idle(1);
    lit_read_0x03();
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), 8'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
              1'($urandom), rdly(), rdly(), rdly(), rdly(), rdly(), -1);
      idle(int'($urandom_range(2, 0)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter: ADDR_WIDTH, 8, width of reg_address and cmd_addr.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, maximum cycles in any wait state before abort (1..65535).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  host requests a transaction.
REQ-006 cmd_ready  out  1  initiator accepts a command this cycle.
REQ-007 cmd_rw  in  1  1 = read register, 0 = write register.
REQ-008 cmd_addr  in  ADDR_WIDTH  target register number.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse: response fields valid.
REQ-011 rsp_rdata  out  32  data word returned (read); 0 for write or timeout.
REQ-012 rsp_status  out  32  status word returned by subsystem.
REQ-013 rsp_fault  out  1  nFault observed low during transaction.
REQ-014 rsp_timeout  out  1  transaction aborted by timeout.
REQ-015 register_address_valid  out  1  reg_address/RW stable and valid.
REQ-016 reg_address  out  ADDR_WIDTH  register number on bus.
REQ-017 RW  out  1  bus direction, copy of latched cmd_rw.
REQ-018 handshake_1  out  1  initiator strobe.
REQ-019 handshake_2  in  1  subsystem acknowledge.
REQ-020 data_out  out  32  write data to subsystem.
REQ-021 data_in  in  32  data/status word from subsystem.
REQ-022 nFault  in  1  active-low fault; any value other than 1'b0 is "no fault".

Function
REQ-023 States SHALL be IDLE, SETUP, DATA_REQ, DATA_REL, STAT_REQ, STAT_REL, DONE.
REQ-024 IDLE: cmd_ready=1; on cmd_valid latch cmd_rw/cmd_addr/cmd_wdata, clear fault flag, go SETUP next cycle; cmd_ready=0 in all other states.
REQ-025 SETUP through STAT_REL: register_address_valid=1, reg_address/RW/data_out held from latched values, no change mid-transaction.
REQ-026 SETUP: handshake_1=0; advance to DATA_REQ once handshake_2=0 (stale acknowledge blocks start).
REQ-027 DATA_REQ: handshake_1=1; on first cycle handshake_2=1, capture data_in into rsp_rdata if read, sample nFault, go DATA_REL.
REQ-028 DATA_REL: handshake_1=0; on handshake_2=0 go STAT_REQ.
REQ-029 STAT_REQ: handshake_1=1; on handshake_2=1 capture data_in into rsp_status, sample nFault, go STAT_REL.
REQ-030 STAT_REL: handshake_1=0; on handshake_2=0 go DONE.
REQ-031 DONE: one cycle, rsp_valid=1, register_address_valid=0, then IDLE; response registers hold until next DONE.
REQ-032 Fault flag SHALL be sticky per transaction: set if nFault=0 at either capture cycle.
REQ-033 Timeout counter (16 bit) SHALL clear on every state entry and increment each cycle in SETUP/DATA_REQ/DATA_REL/STAT_REQ/STAT_REL.
REQ-034 If counter reaches TIMEOUT_CYCLES before the awaited event, go DONE with rsp_timeout=1, rsp_rdata=0, rsp_status=0, handshake_1=0 that cycle.
REQ-035 Awaited event and timeout in same cycle: event SHALL win.
REQ-036 Minimum transaction: 6 cycles from acceptance to rsp_valid with zero-wait responder; earliest next acceptance the cycle after DONE.
REQ-037 data_out SHALL equal latched cmd_wdata for writes and 0 for reads.

Reset
REQ-038 While reset=1, immediately: state IDLE, cmd_ready=0 (1 from first cycle after release), handshake_1=0, register_address_valid=0, reg_address=0, RW=0, data_out=0, rsp_valid=0, rsp_rdata=0, rsp_status=0, rsp_fault=0, rsp_timeout=0, counter=0.
REQ-039 Reset mid-transaction SHALL abort with no rsp_valid; subsequent transaction starts at SETUP normally.

Verification
REQ-040 Read addr 0x03, responder returns 0x12345678 then status 0x00000001 -> rsp_valid, rsp_rdata=0x12345678, rsp_status=0x00000001, fault=0, timeout=0.
REQ-041 Write addr 0x05 data 0xDEADBEEF -> data_out=0xDEADBEEF, RW=0 throughout, rsp_rdata=0, rsp_status from responder.
REQ-042 Read unmapped register with responder returning 0x55555555, nFault=0, status 0xAAAAAAAA -> rsp_fault=1, rsp_rdata=0x55555555, rsp_status=0xAAAAAAAA.
REQ-043 handshake_2 never asserted, TIMEOUT_CYCLES=8 -> rsp_timeout=1 exactly 8 cycles after entering DATA_REQ, handshake_1=0, back in IDLE.
REQ-044 handshake_2 stuck high at command accept -> stays in SETUP, handshake_1 never asserted, timeout reported.
REQ-045 Reset asserted during STAT_REQ -> all outputs at REQ-038 values same cycle, no rsp_valid; following read completes correctly.
